// File: rtl/uart_retrans_param.sv
// uart_retrans_param: UART frame receiver with parity/stop checking and timed resend requests
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   signal         serial line, one bit per clk, idle high
//   ack            consumer acknowledge of the held frame
//   valid          a good frame is held on data
//   data           received payload, LSB received first
//   error          a parity or stop-bit fault is pending
//   request_resend one-cycle retransmission request
//   resend_count   resend requests since the last acked frame (saturates at 31)
//   give_up        sticky, retry limit exhausted
//
// Optional feature: define UART_RETRANS_ACK_TIMEOUT_EN to time out an unacked frame
// after TIMEOUT_CYCLES cycles and treat it as an error.
module uart_retrans_param #(
  parameter int DATA_BITS      = 7,
  parameter int PARITY_ODD     = 0,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 signal,
  input  logic                 ack,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 error,
  output logic                 request_resend,
  output logic [4:0]           resend_count,
  output logic                 give_up
);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_ACK, ERR, FAIL} state_t;
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] BLAST = 4'(DATA_BITS - 1);
  localparam logic [4:0] RMAX  = 5'(MAX_RETRIES);
  state_t state, state_n;
  logic [DATA_BITS-1:0] sh, sh_n, data_n;
  logic [3:0] bits, bits_n;
  logic [7:0] tmr, tmr_n;
  logic [4:0] rc_n;
  logic par_ok, par_ok_n, valid_n, error_n, rr_n, gu_n;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      sh             <= '0;
      bits           <= '0;
      tmr            <= '0;
      par_ok         <= 1'b0;
      valid          <= 1'b0;
      data           <= '0;
      error          <= 1'b0;
      request_resend <= 1'b0;
      resend_count   <= '0;
      give_up        <= 1'b0;
    end else begin
      state          <= state_n;
      sh             <= sh_n;
      bits           <= bits_n;
      tmr            <= tmr_n;
      par_ok         <= par_ok_n;
      valid          <= valid_n;
      data           <= data_n;
      error          <= error_n;
      request_resend <= rr_n;
      resend_count   <= rc_n;
      give_up        <= gu_n;
    end
  end
  always_comb begin
    state_n  = state;
    sh_n     = sh;
    bits_n   = bits;
    tmr_n    = tmr;
    par_ok_n = par_ok;
    valid_n  = valid;
    data_n   = data;
    error_n  = error;
    rr_n     = 1'b0;
    rc_n     = resend_count;
    gu_n     = give_up;
    case (state)
      IDLE: begin
        bits_n  = '0;
        state_n = signal ? IDLE : DATA;
      end
      DATA: begin
        sh_n    = {signal, sh[DATA_BITS-1:1]};
        bits_n  = bits + 4'd1;
        state_n = (bits == BLAST) ? PARITY : DATA;
      end
      PARITY: begin
        par_ok_n = ((^sh) ^ signal) == PARITY_ODD[0];
        state_n  = STOP;
      end
      STOP: begin
        tmr_n = '0;
        if (signal && par_ok) begin
          state_n = WAIT_ACK;
          valid_n = 1'b1;
          data_n  = sh;
        end else begin
          state_n = ERR;
          error_n = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          state_n = IDLE;
          valid_n = 1'b0;
          rc_n    = '0;
        end
`ifdef UART_RETRANS_ACK_TIMEOUT_EN
        else if (tmr == TLAST) begin
          state_n = ERR;
          valid_n = 1'b0;
          error_n = 1'b1;
          tmr_n   = '0;
        end else tmr_n = tmr + 8'd1;
`endif
      end
      ERR: begin
        tmr_n = tmr + 8'd1;
        if (tmr == TLAST) begin
          if (resend_count < RMAX) begin
            state_n = IDLE;
            rr_n    = 1'b1;
            error_n = 1'b0;
            rc_n    = (resend_count == 5'd31) ? resend_count : resend_count + 5'd1;
          end else begin
            state_n = FAIL;
            gu_n    = 1'b1;
          end
        end
      end
      FAIL: state_n = FAIL;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_retrans_param.sv
// tb_uart_retrans_param: randomized self-checking bench with a frame-level reference model
module tb_uart_retrans_param;
  localparam int DB   = 7;
  localparam int PODD = 0;
  localparam int T    = 8;
  localparam int MR   = 3;
  logic clk, reset, signal, ack;
  logic valid, error, request_resend, give_up;
  logic [DB-1:0] data;
  logic [4:0] resend_count;
  int n_chk = 0;
  int n_fail = 0;
  uart_retrans_param #(.DATA_BITS(DB), .PARITY_ODD(PODD), .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)) dut (
    .clk(clk), .reset(reset), .signal(signal), .ack(ack), .valid(valid), .data(data),
    .error(error), .request_resend(request_resend), .resend_count(resend_count), .give_up(give_up)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic good_par(input logic [DB-1:0] d);
    return 1'(($countones(d) + PODD) % 2);
  endfunction
  task automatic send(input logic [DB-1:0] d, input logic p, input logic s);
    signal = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      signal = d[i];
      @(negedge clk);
    end
    signal = p;
    @(negedge clk);
    signal = s;
    @(negedge clk);
    signal = 1'b1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    signal = 1'b1;
    ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({valid, error, request_resend, give_up, resend_count, data} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b e=%b rr=%b gu=%b rc=%0d d=%h want all 0", valid, error, request_resend, give_up, resend_count, data);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_good_frame();
    send(7'h55, 1'b0, 1'b1);
    n_chk++;
    if ({valid, error, data} !== {2'b10, 7'h55}) begin
      n_fail++;
      $display("FAIL good_frame: got v=%b e=%b d=%h want v=1 e=0 d=55", valid, error, data);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL good_hold: got v=%b want 1", valid);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_chk++;
    if ({valid, resend_count, data} !== {1'b0, 5'd0, 7'h55}) begin
      n_fail++;
      $display("FAIL good_ack: got v=%b rc=%0d d=%h want v=0 rc=0 d=55", valid, resend_count, data);
    end
  endtask
  task automatic test_parity_error();
    send(7'h55, 1'b1, 1'b1);
    for (int i = 0; i < T; i++) begin
      n_chk++;
      if ({error, request_resend, valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL par_err_hold[%0d]: got e=%b rr=%b v=%b want e=1 rr=0 v=0", i, error, request_resend, valid);
      end
      @(negedge clk);
    end
    n_chk++;
    if ({error, request_resend, resend_count} !== {2'b01, 5'd1}) begin
      n_fail++;
      $display("FAIL par_err_pulse: got e=%b rr=%b rc=%0d want e=0 rr=1 rc=1", error, request_resend, resend_count);
    end
    @(negedge clk);
    n_chk++;
    if (request_resend !== 1'b0) begin
      n_fail++;
      $display("FAIL par_err_one_cycle: got rr=%b want 0", request_resend);
    end
    send(7'h2A, good_par(7'h2A), 1'b1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_chk++;
    if (resend_count !== 5'd0) begin
      n_fail++;
      $display("FAIL rc_clear: got rc=%0d want 0", resend_count);
    end
  endtask
  task automatic test_give_up();
    logic [DB-1:0] d;
    do_reset();
    for (int k = 0; k <= MR; k++) begin
      d = DB'($urandom);
      send(d, ~good_par(d), 1'b1);
      repeat (T) @(negedge clk);
      n_chk++;
      if (k < MR) begin
        if ({request_resend, error, give_up, resend_count} !== {3'b100, 5'(k + 1)}) begin
          n_fail++;
          $display("FAIL retry[%0d]: got rr=%b e=%b gu=%b rc=%0d want rr=1 e=0 gu=0 rc=%0d", k, request_resend, error, give_up, resend_count, k + 1);
        end
      end else if ({request_resend, error, give_up, resend_count} !== {3'b011, 5'(MR)}) begin
        n_fail++;
        $display("FAIL give_up: got rr=%b e=%b gu=%b rc=%0d want rr=0 e=1 gu=1 rc=%0d", request_resend, error, give_up, resend_count, MR);
      end
      @(negedge clk);
    end
    send(7'h11, good_par(7'h11), 1'b1);
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    n_chk++;
    if ({valid, error, give_up, request_resend} !== 4'b0110) begin
      n_fail++;
      $display("FAIL fail_terminal: got v=%b e=%b gu=%b rr=%b want v=0 e=1 gu=1 rr=0", valid, error, give_up, request_resend);
    end
    do_reset();
    n_chk++;
    if ({give_up, error, resend_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_from_fail: got gu=%b e=%b rc=%0d want 0", give_up, error, resend_count);
    end
  endtask
  task automatic test_break();
    send(7'h00, 1'b0, 1'b0);
    n_chk++;
    if ({error, valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL break: got e=%b v=%b want e=1 v=0", error, valid);
    end
    repeat (T) @(negedge clk);
    n_chk++;
    if ({request_resend, resend_count, valid} !== {1'b1, 5'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL break_resend: got rr=%b rc=%0d v=%b want rr=1 rc=1 v=0", request_resend, resend_count, valid);
    end
    do_reset();
  endtask
  task automatic test_reset_mid_frame();
    signal = 1'b0;
    @(negedge clk);
    signal = 1'b1;
    @(negedge clk);
    signal = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    signal = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({valid, error, request_resend, give_up, resend_count, data} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b e=%b rr=%b gu=%b rc=%0d d=%h want all 0", valid, error, request_resend, give_up, resend_count, data);
    end
    reset = 1'b1;
    send(7'h0F, 1'b0, 1'b1);
    n_chk++;
    if ({valid, error, data} !== {2'b10, 7'h0F}) begin
      n_fail++;
      $display("FAIL post_reset_frame: got v=%b e=%b d=%h want v=1 e=0 d=0f", valid, error, data);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask
  task automatic test_ack_ignored();
    logic [DB-1:0] d;
    d = DB'($urandom);
    ack = 1'b1;
    repeat (2) @(negedge clk);
    send(d, good_par(d), 1'b1);
    ack = 1'b0;
    n_chk++;
    if ({valid, data} !== {1'b1, d}) begin
      n_fail++;
      $display("FAIL ack_outside: got v=%b d=%h want v=1 d=%h", valid, data, d);
    end
    for (int i = 0; i < 10; i++) begin
      signal = 1'($urandom);
      @(negedge clk);
    end
    signal = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({valid, data, error} !== {1'b1, d, 1'b0}) begin
      n_fail++;
      $display("FAIL line_in_wait: got v=%b d=%h e=%b want v=1 d=%h e=0", valid, data, error, d);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask
  task automatic test_ack_wait();
    send(7'h3C, good_par(7'h3C), 1'b1);
`ifdef UART_RETRANS_ACK_TIMEOUT_EN
    for (int i = 0; i < T; i++) begin
      n_chk++;
      if (valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ack_to_hold[%0d]: got v=%b want 1", i, valid);
      end
      @(negedge clk);
    end
    n_chk++;
    if ({valid, error} !== 2'b01) begin
      n_fail++;
      $display("FAIL ack_timeout: got v=%b e=%b want v=0 e=1", valid, error);
    end
    repeat (T) @(negedge clk);
    n_chk++;
    if ({request_resend, resend_count} !== {1'b1, 5'd1}) begin
      n_fail++;
      $display("FAIL ack_to_resend: got rr=%b rc=%0d want rr=1 rc=1", request_resend, resend_count);
    end
    do_reset();
`else
    repeat (3 * T) @(negedge clk);
    n_chk++;
    if ({valid, error, data} !== {2'b10, 7'h3C}) begin
      n_fail++;
      $display("FAIL ack_forever: got v=%b e=%b d=%h want v=1 e=0 d=3c", valid, error, data);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
`endif
  endtask
  task automatic test_random();
    int rc, kind;
    logic [DB-1:0] d;
    do_reset();
    rc = 0;
    for (int n = 0; n < 25; n++) begin
      d = DB'($urandom);
      kind = (rc == MR) ? 0 : int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (kind < 2) begin
        send(d, good_par(d), 1'b1);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        n_chk++;
        if ({valid, error, data} !== {2'b10, d}) begin
          n_fail++;
          $display("FAIL rnd_good[%0d]: got v=%b e=%b d=%h want v=1 e=0 d=%h", n, valid, error, data, d);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        rc = 0;
        n_chk++;
        if ({valid, resend_count} !== 6'd0) begin
          n_fail++;
          $display("FAIL rnd_ack[%0d]: got v=%b rc=%0d want v=0 rc=0", n, valid, resend_count);
        end
      end else begin
        send(d, (kind == 2) ? ~good_par(d) : good_par(d), (kind == 2) ? 1'($urandom) : 1'b0);
        n_chk++;
        if ({error, valid} !== 2'b10) begin
          n_fail++;
          $display("FAIL rnd_err[%0d]: got e=%b v=%b want e=1 v=0", n, error, valid);
        end
        repeat (T) @(negedge clk);
        rc++;
        n_chk++;
        if ({request_resend, error, resend_count} !== {2'b10, 5'(rc)}) begin
          n_fail++;
          $display("FAIL rnd_resend[%0d]: got rr=%b e=%b rc=%0d want rr=1 e=0 rc=%0d", n, request_resend, error, resend_count, rc);
        end
      end
    end
  endtask
  initial begin
    reset = 1'b0;
    signal = 1'b1;
    ack = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_give_up();
    test_break();
    test_reset_mid_frame();
    test_ack_ignored();
    test_ack_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_retrans_param.md
UART_RETRANS_PARAM -- requirements
Module: uart_retrans_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 7, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 8: cycles from error detection to the resend request (legal 1..255).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: resend requests permitted before give-up (legal 1..31).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port signal, input, 1 bit: serial line, one bit per clk, idle high.
REQ-008 SHALL have port ack, input, 1 bit: consumer acknowledge of a valid frame.
REQ-009 SHALL have port valid, output, 1 bit: a good frame is held on data.
REQ-010 SHALL have port data, output, DATA_BITS bits: received payload, LSB received first.
REQ-011 SHALL have port error, output, 1 bit: a parity or stop-bit fault is pending.
REQ-012 SHALL have port request_resend, output, 1 bit: one-cycle pulse requesting retransmission.
REQ-013 SHALL have port resend_count, output, 5 bits: resend requests issued since the last acked frame.
REQ-014 SHALL have port give_up, output, 1 bit: sticky; the retry limit has been exhausted.

Function
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP, WAIT_ACK, ERR and FAIL, and SHALL register all outputs.
REQ-016 IDLE: signal=0 sampled -> DATA; signal=1 -> stay in IDLE.
REQ-017 DATA: SHALL shift in exactly DATA_BITS samples, LSB first, then -> PARITY.
REQ-018 PARITY: parity is OK when the count of data ones plus P is even (PARITY_ODD=0) or odd (PARITY_ODD=1); then -> STOP.
REQ-019 STOP: signal=1 with parity OK -> WAIT_ACK; valid=1 and data loaded from the cycle after the stop sample.
REQ-020 STOP: parity bad or signal=0 (break) -> ERR; error=1 from the cycle after the stop sample.
REQ-021 WAIT_ACK: ack=1 -> IDLE; valid clears next cycle; resend_count clears to 0; data holds its last value.
REQ-022 ack outside WAIT_ACK SHALL be ignored.
REQ-023 Line activity during WAIT_ACK, ERR or FAIL SHALL be ignored; a new start bit is detected only in IDLE.
REQ-024 ERR: error SHALL be held for exactly TIMEOUT_CYCLES cycles.
REQ-025 ERR exit with resend_count < MAX_RETRIES: request_resend=1 for one cycle, resend_count increments, error clears, -> IDLE.
REQ-026 ERR exit with resend_count = MAX_RETRIES: no pulse; error stays 1; give_up=1; -> FAIL.
REQ-027 FAIL is terminal until reset.
REQ-028 resend_count SHALL saturate at 31 and never wrap.
REQ-029 The timeout counter SHALL be 8 bits, SHALL load 0 on entry to ERR, and SHALL be unused in other states unless REQ-035 applies.

Reset
REQ-030 reset=0 at a rising clk edge: state=IDLE; valid, error, request_resend and give_up = 0; resend_count = 0; data = 0; shift and timeout counters = 0.
REQ-031 Reset SHALL take priority over every event, including mid-frame and in FAIL.
REQ-032 After reset release the first sampled 0 on signal SHALL be treated as a start bit.

Configuration
REQ-033 SHALL use macro UART_RETRANS_ACK_TIMEOUT_EN.
REQ-034 Macro undefined: WAIT_ACK waits for ack indefinitely.
REQ-035 Macro defined: TIMEOUT_CYCLES cycles in WAIT_ACK without ack -> valid clears and the FSM enters ERR (error=1), then follows REQ-024..026.
REQ-036 Macro defined: ack in the same cycle as the timeout expiry wins (-> IDLE).

Verification (defaults: DATA_BITS=7, even parity, TIMEOUT_CYCLES=8, MAX_RETRIES=3)
REQ-037 Frame 0,1,0,1,0,1,0,1,P=0,stop=1 -> valid=1, data=7'h55, error=0; ack pulse -> valid=0, resend_count=0.
REQ-038 Same frame with P=1 -> error=1 for 8 cycles, then request_resend pulses 1 cycle, resend_count=1, FSM returns to IDLE.
REQ-039 Four consecutive bad-parity frames -> resend_count=3 after the third pulse; fourth error -> give_up=1, error stays 1, no fourth pulse; a later good frame is ignored.
REQ-040 All-zero data, P=0, stop=0 (break) -> error=1, valid stays 0.
REQ-041 reset=0 asserted in the middle of DATA -> all outputs 0 next cycle; a following good frame 7'h0F, P=0 -> valid=1, data=7'h0F.
REQ-042 With UART_RETRANS_ACK_TIMEOUT_EN: good frame with no ack for 8 cycles -> valid=0, error=1, and request_resend pulses 8 cycles later.
